// File: rtl/io_port_ctrl.sv
// Load-control sequencer for the Inport/Outport registers: valid/ready intake from the
// device, write-then-hold-valid output with acknowledge timeout, and sticky error flags.
module io_port_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic clr,
    input  logic dev_in_valid,
    output logic dev_in_ready,
    output logic in_strobe,
    output logic in_full,
    input  logic cpu_in_rd,
    input  logic cpu_out_wr,
    output logic out_load,
    output logic dev_out_valid,
    input  logic dev_out_ack,
    output logic cpu_stall,
    input  logic err_clr,
    output logic underrun,
    output logic out_timeout
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

    typedef enum logic {IN_EMPTY  = 1'b0, IN_FULL  = 1'b1} in_state_t;
    typedef enum logic {OUT_IDLE  = 1'b0, OUT_WAIT = 1'b1} out_state_t;

    in_state_t      in_state, in_next;
    out_state_t     out_state, out_next;
    logic [TW-1:0]  timer, timer_next;
    logic           underrun_set, timeout_set;

    // ---------------- input FSM ----------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) in_state <= IN_EMPTY;
        else      in_state <= in_next;
    end

    always_comb begin
        in_next      = in_state;
        underrun_set = 1'b0;
        case (in_state)
            IN_EMPTY: begin
                if (dev_in_valid) in_next = IN_FULL;
                underrun_set = cpu_in_rd;
            end
            IN_FULL: if (cpu_in_rd) in_next = IN_EMPTY;
            default: in_next = IN_EMPTY;
        endcase
    end

    always_comb begin
        dev_in_ready = (in_state == IN_EMPTY);
        in_full      = (in_state == IN_FULL);
        in_strobe    = dev_in_valid & dev_in_ready & clr;
    end

    // ---------------- output FSM ----------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_state <= OUT_IDLE;
            timer     <= '0;
        end else begin
            out_state <= out_next;
            timer     <= timer_next;
        end
    end

    // Ack is tested first so an ack at terminal count never flags a timeout.
    always_comb begin
        out_next    = out_state;
        timer_next  = timer;
        timeout_set = 1'b0;
        case (out_state)
            OUT_IDLE: if (cpu_out_wr) begin
                out_next   = OUT_WAIT;
                timer_next = '0;
            end
            OUT_WAIT: begin
                if (dev_out_ack) begin
                    out_next = OUT_IDLE;
                end else if (timer == TERM) begin
                    out_next    = OUT_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    always_comb begin
        dev_out_valid = (out_state == OUT_WAIT);
        out_load      = cpu_out_wr & (out_state == OUT_IDLE) & clr;
        cpu_stall     = cpu_out_wr & (out_state == OUT_WAIT) & clr;
    end

    // ---------------- sticky error flags ----------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            underrun    <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            if (underrun_set)  underrun <= 1'b1;
            else if (err_clr)  underrun <= 1'b0;
            if (timeout_set)   out_timeout <= 1'b1;
            else if (err_clr)  out_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboard bench for io_port_ctrl (TIMEOUT=4): bench-side Inport/Outport models
// capture on the strobes, expected words are queued at stimulus time.
module tb_io_port_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b0;
    logic dev_in_valid = 1'b0, cpu_in_rd = 1'b0, cpu_out_wr = 1'b0;
    logic dev_out_ack = 1'b0, err_clr = 1'b0;
    logic dev_in_ready, in_strobe, in_full, out_load, dev_out_valid, cpu_stall;
    logic underrun, out_timeout;
    logic [31:0] din = '0, bus = '0, inport_q = '0, outport_q = '0;
    logic [31:0] in_exp_q[$];
    logic [31:0] out_exp_q[$];
    int checks = 0;
    int errors = 0;

    io_port_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .clr(clr),
        .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
        .in_strobe(in_strobe), .in_full(in_full), .cpu_in_rd(cpu_in_rd),
        .cpu_out_wr(cpu_out_wr), .out_load(out_load), .dev_out_valid(dev_out_valid),
        .dev_out_ack(dev_out_ack), .cpu_stall(cpu_stall), .err_clr(err_clr),
        .underrun(underrun), .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Drive just after the active edge, then look mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {dev_in_ready, in_strobe, in_full, out_load,
                dev_out_valid, cpu_stall, underrun, out_timeout};
    endfunction

    // Port register models and scoreboard pop, sampled mid-cycle where strobes are stable.
    always @(negedge clk) begin
        if (in_strobe) begin
            inport_q <= din;
            if (in_exp_q.size() == 0) chk("in_unexpected_strobe", 32'd1, 32'd0);
            else chk("in_data", din, in_exp_q.pop_front());
        end
        if (out_load) begin
            outport_q <= bus;
            if (out_exp_q.size() == 0) chk("out_unexpected_load", 32'd1, 32'd0);
            else chk("out_data", bus, out_exp_q.pop_front());
        end
    end

    initial begin
        int n;
        // ---- reset with random inputs ----
        for (int i = 0; i < 4; i++) begin
            cyc();
            {dev_in_valid, cpu_in_rd, cpu_out_wr, dev_out_ack, err_clr} = 5'($urandom);
            @(negedge clk);
            chk("reset_outs", 32'(outs()), 32'h80);
        end
        cyc();
        {dev_in_valid, cpu_in_rd, cpu_out_wr, dev_out_ack, err_clr} = '0;
        clr = 1'b1;
        @(negedge clk);
        chk("post_reset_outs", 32'(outs()), 32'h80);

        // ---- input handshake ----
        cyc(); din = 32'h2; dev_in_valid = 1'b1; in_exp_q.push_back(32'h2);
        @(negedge clk); chk("hs_strobe", 32'(in_strobe), 32'd1);
        cyc();
        @(negedge clk);
        chk("hs_full", 32'({in_full, dev_in_ready, in_strobe}), 32'b100);
        chk("inport_q", inport_q, 32'h2);
        cyc(); cpu_in_rd = 1'b1;
        @(negedge clk); chk("rd_no_bypass", 32'({in_strobe, dev_in_ready}), 32'b00);
        // continuous valid: strobe every other cycle while read each time
        for (int k = 0; k < 3; k++) begin
            cyc(); cpu_in_rd = 1'b0; din = 32'h100 + 32'(k); in_exp_q.push_back(din);
            @(negedge clk); chk("stream_strobe", 32'({in_strobe, in_full}), 32'b10);
            cyc(); cpu_in_rd = 1'b1;
            @(negedge clk); chk("stream_gap", 32'({in_strobe, in_full}), 32'b01);
        end
        cyc(); cpu_in_rd = 1'b0; dev_in_valid = 1'b0;
        @(negedge clk); chk("stream_empty", 32'({in_full, dev_in_ready}), 32'b01);
        chk("inport_last", inport_q, 32'h102);

        // ---- underrun ----
        cyc(); cpu_in_rd = 1'b1;
        cyc(); cpu_in_rd = 1'b0;
        @(negedge clk); chk("underrun_set", 32'({underrun, in_full}), 32'b10);
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0;
        @(negedge clk); chk("underrun_clr", 32'(underrun), 32'd0);
        cyc(); err_clr = 1'b1; cpu_in_rd = 1'b1;
        cyc(); err_clr = 1'b0; cpu_in_rd = 1'b0;
        @(negedge clk); chk("underrun_set_wins", 32'(underrun), 32'd1);
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0;

        // ---- output with ack on 3rd valid cycle ----
        dev_out_ack = 1'b1;  // ack in idle is ignored
        @(negedge clk); chk("ack_idle", 32'(dev_out_valid), 32'd0);
        cyc(); dev_out_ack = 1'b0; cpu_out_wr = 1'b1; bus = 32'hDEADBEEF;
        out_exp_q.push_back(bus);
        @(negedge clk); chk("wr_load", 32'({out_load, cpu_stall}), 32'b10);
        cyc(); bus = 32'h12345678;
        @(negedge clk); chk("wr_stall", 32'({out_load, cpu_stall, dev_out_valid}), 32'b011);
        cyc(); cpu_out_wr = 1'b0;
        @(negedge clk); chk("outport_kept", outport_q, 32'hDEADBEEF);
        chk("valid_2", 32'(dev_out_valid), 32'd1);
        cyc(); dev_out_ack = 1'b1;
        @(negedge clk); chk("valid_3", 32'(dev_out_valid), 32'd1);
        // new write accepted in first cycle after exit
        cyc(); dev_out_ack = 1'b0; cpu_out_wr = 1'b1; bus = 32'hCAFEF00D;
        out_exp_q.push_back(bus);
        @(negedge clk);
        chk("ack_drop", 32'({dev_out_valid, out_timeout, out_load}), 32'b001);

        // ---- timeout: valid for exactly TIMEOUT cycles ----
        n = 0;
        cyc(); cpu_out_wr = 1'b0;
        @(negedge clk);
        while (dev_out_valid && n < 20) begin
            n++;
            cyc();
            @(negedge clk);
        end
        chk("timeout_len", 32'(n), 32'd4);
        chk("timeout_flag", 32'(out_timeout), 32'd1);
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0;
        @(negedge clk); chk("timeout_clr", 32'(out_timeout), 32'd0);

        // ---- ack at terminal count: ack wins ----
        cpu_out_wr = 1'b1; bus = 32'h0000_0044; out_exp_q.push_back(bus);
        cyc(); cpu_out_wr = 1'b0;
        cyc(); cyc();
        cyc(); dev_out_ack = 1'b1;
        @(negedge clk); chk("term_valid4", 32'(dev_out_valid), 32'd1);
        cyc(); dev_out_ack = 1'b0;
        @(negedge clk); chk("term_ack_wins", 32'({dev_out_valid, out_timeout}), 32'b00);

        // ---- async reset mid IN_FULL / OUT_WAIT ----
        cyc(); dev_in_valid = 1'b1; din = 32'h77; in_exp_q.push_back(din);
        cpu_out_wr = 1'b1; bus = 32'h55; out_exp_q.push_back(bus);
        cyc(); cpu_out_wr = 1'b0;
        @(negedge clk); chk("pre_rst", 32'({in_full, dev_out_valid}), 32'b11);
        #2 clr = 1'b0;
        #1 chk("async_rst", 32'(outs()), 32'h80);
        cyc(); clr = 1'b1; dev_in_valid = 1'b0;
        @(negedge clk); chk("rst_release", 32'(outs()), 32'h80);

        chk("in_sb_drained", 32'(in_exp_q.size()), 32'd0);
        chk("out_sb_drained", 32'(out_exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
